bcd_countdown_timer: RTL and testbench

//  Two-digit BCD countdown timer: loads 00..99 from switches, decrements once per

---
 rtl/bcd_countdown_timer.sv | 183 ++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with a clock-enable prescaler.
// Loads 00..99 from switches, counts down one step per prescaler tick,
// stops at 00 with done raised, and drives an active-low 7-segment pair.
module bcd_countdown_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] load_val,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       running,
  output logic       done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Limit a raw switch nibble to a legal BCD digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One BCD step down; saturates at 00 and never yields a non-BCD digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] c);
    logic [7:0] r;
    if (c[3:0] != 4'd0) begin
      r = {c[7:4], c[3:0] - 4'd1};
    end else if (c[7:4] != 4'd0) begin
      r = {c[7:4] - 4'd1, 4'd9};
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit; blank otherwise.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          start_q, start_d;
  logic          pause_q, pause_d;

  logic          start_p;
  logic          pause_p;
  logic          tick;
  logic [7:0]    count;
  logic [7:0]    count_dec;

  assign start_p   = start & ~start_q;
  assign pause_p   = pause & ~pause_q;
  assign tick      = (pre_q == DIV_M1);
  assign count     = {tens_q, ones_q};
  assign count_dec = bcd_dec(count);

  // Next-state logic: priority load > start edge > pause edge > tick.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_d   = pre_q;
    start_d = start;
    pause_d = pause;

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (load) begin
          tens_d = clamp_digit(load_val[7:4]);
          ones_d = clamp_digit(load_val[3:0]);
        end else if (start_p) begin
          state_d = (count == 8'h00) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        // load and start are deliberately ignored while counting.
        if (pause_p) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          pre_d = '0;
          if (count == 8'h01) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = S_DONE;
          end else begin
            tens_d = count_dec[7:4];
            ones_d = count_dec[3:0];
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      S_PAUSED: begin
        // Prescaler frozen so a resume keeps the tick phase.
        if (load) begin
          tens_d  = clamp_digit(load_val[7:4]);
          ones_d  = clamp_digit(load_val[3:0]);
          pre_d   = '0;
          state_d = S_IDLE;
        end else if (start_p) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        pre_d = '0;
        if (load) begin
          tens_d  = clamp_digit(load_val[7:4]);
          ones_d  = clamp_digit(load_val[3:0]);
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
      end
    endcase
  end

  // State, count, prescaler and edge-detect registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      pre_q   <= '0;
      // Held keys must not register as a fresh edge after reset.
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pre_q   <= pre_d;
      start_q <= start_d;
      pause_q <= pause_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign hex1    = seg7(tens_q);
  assign hex0    = seg7(ones_q);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (CLK_HZ=10, TICK_HZ=1, DIV=10).
`timescale 1ns/1ps
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] load_val;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       running;
  logic       done;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .load_val (load_val),
    .load     (load),
    .start    (start),
    .pause    (pause),
    .tens     (tens),
    .ones     (ones),
    .hex1     (hex1),
    .hex0     (hex0),
    .running  (running),
    .done     (done)
  );

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       d;
    int         wait_c;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Queue an expectation: decimal value, running, done, negedges to wait first.
  function automatic void push(input int val, input bit r, input bit d, input int w, input string tag);
    exp_t e;
    e.t = 4'(val / 10);
    e.o = 4'(val % 10);
    e.r = r;
    e.d = d;
    e.wait_c = w;
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 8'h00;
    cyc(2);
    reset_n = 1'b1;
    push(0, 0, 0, 0, "reset_state");
    push(0, 0, 0, 4, "idle_after_reset");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.wait_c);
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b hex=%b/%b, want %h%h run=%b done=%b hex=%b/%b",
                 e.tag, tens, ones, running, done, hex1, hex0, e.t, e.o, e.r, e.d, seg(e.t), seg(e.o));
      end
    end
  endtask

  task automatic test_countdown();
    exp_t e;
    load_val = 8'h12; load = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b1;
    push(12, 1, 0, 1, "start_12");
    for (int k = 1; k <= 12; k++) begin
      push(13 - k, 1, 0, 9, "hold_before_tick");
      push(12 - k, (k < 12), (k == 12), 1, "tick");
    end
    e = sb.pop_front();
    cyc(e.wait_c);
    start = 1'b0;
    checks++;
    if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
      errors++;
      $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
               e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.wait_c);
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b hex=%b/%b, want %h%h run=%b done=%b hex=%b/%b",
                 e.tag, tens, ones, running, done, hex1, hex0, e.t, e.o, e.r, e.d, seg(e.t), seg(e.o));
      end
    end
    // start in DONE has no effect; load leaves DONE for IDLE
    start = 1'b1;
    push(0, 0, 1, 1, "start_in_done");
    e = sb.pop_front();
    cyc(e.wait_c);
    start = 1'b0;
    load_val = 8'h07; load = 1'b1;
    push(7, 0, 0, 1, "load_leaves_done");
    sb.push_front(e);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.tag == "load_leaves_done") cyc(e.wait_c);
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b hex=%b/%b, want %h%h run=%b done=%b hex=%b/%b",
                 e.tag, tens, ones, running, done, hex1, hex0, e.t, e.o, e.r, e.d, seg(e.t), seg(e.o));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_clamp();
    exp_t e;
    logic [7:0] vals [3];
    int         want [3];
    vals[0] = 8'h3F; want[0] = 39;
    vals[1] = 8'hA5; want[1] = 95;
    vals[2] = 8'hAA; want[2] = 99;
    for (int i = 0; i < 3; i++) begin
      load_val = vals[i]; load = 1'b1;
      push(want[i], 0, 0, 1, "clamp_load");
      e = sb.pop_front();
      cyc(e.wait_c);
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s[%0d]: got %h%h hex=%b/%b, want %h%h hex=%b/%b",
                 e.tag, i, tens, ones, hex1, hex0, e.t, e.o, seg(e.t), seg(e.o));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_pause_resume();
    exp_t e;
    load_val = 8'h05; load = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b1;
    push(5, 1, 0, 1, "pr_start");
    push(5, 1, 0, 9, "pr_hold");
    push(4, 1, 0, 1, "pr_first_tick");
    push(4, 1, 0, 3, "pr_before_pause");
    for (int phase = 0; phase < 4; phase++) begin
      e = sb.pop_front();
      cyc(e.wait_c);
      if (phase == 0) start = 1'b0;
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
                 e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
      end
    end
    // pause edge sampled 14 cycles into the run: prescaler frozen at 3
    pause = 1'b1;
    push(4, 0, 0, 1, "pr_paused");
    push(4, 0, 0, 50, "pr_hold_50");
    push(4, 1, 0, 1, "pr_resumed");
    push(4, 1, 0, 6, "pr_phase_hold");
    push(3, 1, 0, 1, "pr_tick_after_7");
    for (int phase = 0; phase < 5; phase++) begin
      e = sb.pop_front();
      if (phase == 2) start = 1'b1;
      cyc(e.wait_c);
      if (phase == 0) pause = 1'b0;
      if (phase == 2) start = 1'b0;
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
                 e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
      end
    end
    // reset while counting returns to the reset state on the next cycle
    reset_n = 1'b0;
    push(0, 0, 0, 1, "reset_mid_count");
    e = sb.pop_front();
    cyc(e.wait_c);
    reset_n = 1'b1;
    checks++;
    if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
      errors++;
      $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
               e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
    end
  endtask

  task automatic test_run_ignore();
    exp_t e;
    load_val = 8'h20; load = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b1;
    push(20, 1, 0, 1, "ri_start");
    push(20, 1, 0, 3, "ri_running");
    push(20, 1, 0, 1, "ri_load_ignored");
    push(20, 0, 0, 1, "ri_start_pause_same");
    push(50, 0, 0, 1, "ri_load_in_paused");
    for (int phase = 0; phase < 5; phase++) begin
      e = sb.pop_front();
      if (phase == 2) begin load_val = 8'h50; load = 1'b1; end
      if (phase == 3) begin load = 1'b0; start = 1'b1; pause = 1'b1; end
      if (phase == 4) begin start = 1'b0; pause = 1'b0; load = 1'b1; end
      cyc(e.wait_c);
      if (phase == 0) start = 1'b0;
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
                 e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_zero_and_reset_hold();
    exp_t e;
    load_val = 8'h00; load = 1'b1;
    push(0, 0, 0, 1, "zh_load_00");
    push(0, 0, 1, 1, "zh_start_at_00");
    push(0, 0, 0, 1, "zh_reset_held_start");
    push(5, 0, 0, 1, "zh_load_05");
    push(5, 0, 0, 5, "zh_no_run_while_held");
    push(5, 1, 0, 2, "zh_fresh_start");
    for (int phase = 0; phase < 6; phase++) begin
      e = sb.pop_front();
      if (phase == 1) begin load = 1'b0; start = 1'b1; end
      if (phase == 2) reset_n = 1'b0;
      if (phase == 3) begin reset_n = 1'b1; load_val = 8'h05; load = 1'b1; end
      if (phase == 4) load = 1'b0;
      if (phase == 5) begin
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(e.wait_c - 1);
      end else begin
        cyc(e.wait_c);
      end
      checks++;
      if ({tens, ones, running, done, hex1, hex0} !== {e.t, e.o, e.r, e.d, seg(e.t), seg(e.o)}) begin
        errors++;
        $display("FAIL %s: got %h%h run=%b done=%b, want %h%h run=%b done=%b",
                 e.tag, tens, ones, running, done, e.t, e.o, e.r, e.d);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown();
    test_clamp();
    test_pause_resume();
    test_run_ignore();
    test_zero_and_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
